// File: rtl/rwait_timer.sv
// ---------------------------------------------------------------------------
// rwait_timer
//
// Random-wait interval generator for the reaction timer. Once armed by
// start_rwait it waits D ticks, where D = MIN_WAIT (fixed mode) or
// MIN_WAIT + lfsr[RAND_W-1:0] (random mode). A tick is TICK_DIV clock
// cycles. The LFSR free-runs from reset, so the moment of arming picks the
// random part. Dropping start_rwait mid-wait aborts with a one-cycle pulse.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   start_rwait  in   1      level: high = run wait, low = idle / abort
//   rand_en      in   1      sampled at load: 1 = add random part
//   r_waitdone   out  1      high while the wait has completed (DONE)
//   busy         out  1      high while waiting (WAIT)
//   aborted      out  1      one-cycle pulse when start_rwait drops in WAIT
//   delay_val    out  CNT_W  delay D chosen at the last load
// ---------------------------------------------------------------------------
module rwait_timer #(
    parameter int          CNT_W     = 32,
    parameter int          MIN_WAIT  = 1000,
    parameter int          RAND_W    = 8,
    parameter int          TICK_DIV  = 100000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_rwait,
    input  logic             rand_en,
    output logic             r_waitdone,
    output logic             busy,
    output logic             aborted,
    output logic [CNT_W-1:0] delay_val
);

    // A one-bit prescaler is kept even for TICK_DIV == 1; it then stays at 0
    // and every edge is a tick.
    localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [PS_W-1:0]  prescaler, prescaler_nx;
    logic [15:0]      lfsr, lfsr_nx;
    logic [CNT_W-1:0] delay_val_nx;
    logic             aborted_nx;

    logic [CNT_W-1:0] rand_part;
    logic [CNT_W-1:0] d_val;
    logic             tick;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            prescaler  <= '0;
            lfsr       <= LFSR_SEED;
            delay_val  <= '0;
            aborted    <= 1'b0;
            r_waitdone <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            prescaler  <= prescaler_nx;
            lfsr       <= lfsr_nx;
            delay_val  <= delay_val_nx;
            aborted    <= aborted_nx;
            // Status flags are registered copies of the next state so they
            // change on the same edge as the state itself.
            r_waitdone <= (state_nx == S_DONE);
            busy       <= (state_nx == S_WAIT);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx     = state;
        count_nx     = count;
        prescaler_nx = prescaler;
        delay_val_nx = delay_val;
        aborted_nx   = 1'b0;

        // 16-bit Fibonacci LFSR, taps 16/14/13/11; free-running in all states.
        lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

        // Candidate delay from the current LFSR value, zero-extended.
        rand_part             = '0;
        rand_part[RAND_W-1:0] = lfsr[RAND_W-1:0];
        d_val = CNT_W'(MIN_WAIT) + (rand_en ? rand_part : '0);

        tick = (prescaler == PS_LAST);

        unique case (state)
            S_IDLE: begin
                if (start_rwait) begin
                    delay_val_nx = d_val;
                    prescaler_nx = '0;
                    if (d_val == '0) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_WAIT;
                        count_nx = d_val;
                    end
                end
            end

            S_WAIT: begin
                // Abort wins over a coincident final tick.
                if (!start_rwait) begin
                    state_nx     = S_IDLE;
                    count_nx     = '0;
                    prescaler_nx = '0;
                    aborted_nx   = 1'b1;
                end else if (tick) begin
                    prescaler_nx = '0;
                    if (count == CNT_W'(1)) begin
                        state_nx = S_DONE;
                        count_nx = '0;
                    end else begin
                        count_nx = count - CNT_W'(1);
                    end
                end else begin
                    prescaler_nx = prescaler + PS_W'(1);
                end
            end

            S_DONE: begin
                // Held until start_rwait drops; no re-trigger from here.
                if (!start_rwait) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rwait_timer.sv
// ---------------------------------------------------------------------------
// tb_rwait_timer
//
// Directed bench for rwait_timer. Two instances share clk/rst:
//   dut_a : MIN_WAIT=3, RAND_W=2, TICK_DIV=2 (fixed, random, abort, reset)
//   dut_z : MIN_WAIT=0, RAND_W=2, TICK_DIV=2 (zero-delay case)
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_rwait_timer;

    localparam int CNT_W = 16;

    logic clk;
    logic rst;

    logic             start_a, rand_a;
    logic             done_a, busy_a, abort_a;
    logic [CNT_W-1:0] delay_a;

    logic             start_z, rand_z;
    logic             done_z, busy_z, abort_z;
    logic [CNT_W-1:0] delay_z;

    int tests_run;
    int tests_failed;

    // Reference LFSR, reset to the documented seed.
    logic [15:0] m_lfsr;
    logic        z_busy_seen;

    rwait_timer #(
        .CNT_W(CNT_W), .MIN_WAIT(3), .RAND_W(2), .TICK_DIV(2), .LFSR_SEED(16'hACE1)
    ) dut_a (
        .clk(clk), .rst(rst), .start_rwait(start_a), .rand_en(rand_a),
        .r_waitdone(done_a), .busy(busy_a), .aborted(abort_a), .delay_val(delay_a)
    );

    rwait_timer #(
        .CNT_W(CNT_W), .MIN_WAIT(0), .RAND_W(2), .TICK_DIV(2), .LFSR_SEED(16'hACE1)
    ) dut_z (
        .clk(clk), .rst(rst), .start_rwait(start_z), .rand_en(rand_z),
        .r_waitdone(done_z), .busy(busy_z), .aborted(abort_z), .delay_val(delay_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    always @(negedge clk) begin
        if (busy_z === 1'b1) z_busy_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges from a load until r_waitdone, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests_run++;
        if ({done_a, busy_a, abort_a} !== 3'b000 || delay_a !== '0) begin
            tests_failed++;
            $display("FAIL reset_a: got done=%b busy=%b aborted=%b delay=%0d, want all 0",
                     done_a, busy_a, abort_a, delay_a);
        end
        tests_run++;
        if ({done_z, busy_z, abort_z} !== 3'b000 || delay_z !== '0) begin
            tests_failed++;
            $display("FAIL reset_z: got done=%b busy=%b aborted=%b delay=%0d, want all 0",
                     done_z, busy_z, abort_z, delay_z);
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_fixed_delay();
        rand_a  = 1'b0;
        start_a = 1'b1;
        step(); // e0: load
        tests_run++;
        if (delay_a !== 16'd3 || busy_a !== 1'b1 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL fixed_load: got delay=%0d busy=%b done=%b, want 3 1 0",
                     delay_a, busy_a, done_a);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            tests_run++;
            if (done_a !== (i == 6) || busy_a !== (i != 6)) begin
                tests_failed++;
                $display("FAIL fixed_edge%0d: got done=%b busy=%b, want done=%b busy=%b",
                         i, done_a, busy_a, (i == 6), (i != 6));
            end
        end
    endtask

    task automatic test_hold_release();
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (done_a !== 1'b1) begin
                tests_failed++;
                $display("FAIL hold%0d: got done=%b, want 1", i, done_a);
            end
        end
        start_a = 1'b0;
        step();
        tests_run++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL release: got done=%b busy=%b, want 0 0", done_a, busy_a);
        end
        step();
        tests_run++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || abort_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_release: got done=%b busy=%b aborted=%b, want 0 0 0",
                     done_a, busy_a, abort_a);
        end
    endtask

    task automatic test_abort();
        int exp_d;
        rand_a  = 1'b0;
        start_a = 1'b1;
        step(); // e0
        tests_run++;
        if (busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_load: got busy=%b, want 1", busy_a);
        end
        for (int i = 1; i <= 2; i++) begin
            step();
            tests_run++;
            if (done_a !== 1'b0 || abort_a !== 1'b0 || busy_a !== 1'b1) begin
                tests_failed++;
                $display("FAIL abort_wait%0d: got done=%b aborted=%b busy=%b, want 0 0 1",
                         i, done_a, abort_a, busy_a);
            end
        end
        start_a = 1'b0;
        step(); // e3
        tests_run++;
        if (abort_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_pulse: got aborted=%b busy=%b done=%b, want 1 0 0",
                     abort_a, busy_a, done_a);
        end
        // Re-arm in the aborted cycle itself, random mode this time.
        rand_a  = 1'b1;
        exp_d   = 3 + int'(m_lfsr[1:0]);
        start_a = 1'b1;
        step();
        tests_run++;
        if (abort_a !== 1'b0 || busy_a !== 1'b1 || delay_a !== CNT_W'(exp_d)) begin
            tests_failed++;
            $display("FAIL abort_rearm: got aborted=%b busy=%b delay=%0d, want 0 1 %0d",
                     abort_a, busy_a, delay_a, exp_d);
        end
        start_a = 1'b0;
        step();
        tests_run++;
        if (abort_a !== 1'b1 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_again: got aborted=%b done=%b, want 1 0", abort_a, done_a);
        end
        rand_a = 1'b0;
        step();
    endtask

    task automatic test_random();
        int offs [6] = '{0, 1, 2, 3, 5, 8};
        int exp_d;
        int n;
        rand_a = 1'b1;
        foreach (offs[k]) begin
            repeat (offs[k]) step();
            exp_d   = 3 + int'(m_lfsr[1:0]);
            start_a = 1'b1;
            step();
            tests_run++;
            if (delay_a !== CNT_W'(exp_d) || delay_a < 16'd3 || delay_a > 16'd6) begin
                tests_failed++;
                $display("FAIL rand_delay%0d: got delay=%0d, want %0d in [3,6]",
                         k, delay_a, exp_d);
            end
            wait_done(n);
            tests_run++;
            if (n != exp_d * 2) begin
                tests_failed++;
                $display("FAIL rand_latency%0d: got %0d edges, want %0d", k, n, exp_d * 2);
            end
            start_a = 1'b0;
            step();
        end
        rand_a = 1'b0;
    endtask

    task automatic test_zero_delay();
        start_z = 1'b1;
        step();
        tests_run++;
        if (done_z !== 1'b1 || busy_z !== 1'b0 || delay_z !== '0) begin
            tests_failed++;
            $display("FAIL zero_load: got done=%b busy=%b delay=%0d, want 1 0 0",
                     done_z, busy_z, delay_z);
        end
        step();
        tests_run++;
        if (done_z !== 1'b1 || busy_z !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_hold: got done=%b busy=%b, want 1 0", done_z, busy_z);
        end
        start_z = 1'b0;
        step();
        tests_run++;
        if (done_z !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_release: got done=%b, want 0", done_z);
        end
        tests_run++;
        if (z_busy_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_busy_seen: got %b, want 0", z_busy_seen);
        end
    endtask

    task automatic test_async_reset();
        int n;
        rand_a  = 1'b0;
        start_a = 1'b1;
        step();
        step();
        step();
        tests_run++;
        if (busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_pre: got busy=%b, want 1", busy_a);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({done_a, busy_a, abort_a} !== 3'b000 || delay_a !== '0) begin
            tests_failed++;
            $display("FAIL areset_clear: got done=%b busy=%b aborted=%b delay=%0d, want all 0",
                     done_a, busy_a, abort_a, delay_a);
        end
        start_a = 1'b0;
        step();
        rst = 1'b0;
        // First load after release sees the seed: 16'hACE1[1:0] = 1 -> D = 4.
        rand_a  = 1'b1;
        start_a = 1'b1;
        step();
        tests_run++;
        if (delay_a !== 16'd4 || abort_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_seed: got delay=%0d aborted=%b, want 4 0", delay_a, abort_a);
        end
        start_a = 1'b0;
        step();
        rand_a = 1'b0;
        step();
        start_a = 1'b1;
        step();
        tests_run++;
        if (delay_a !== 16'd3) begin
            tests_failed++;
            $display("FAIL areset_fixed_delay: got %0d, want 3", delay_a);
        end
        wait_done(n);
        tests_run++;
        if (n != 6) begin
            tests_failed++;
            $display("FAIL areset_fixed_latency: got %0d edges, want 6", n);
        end
        start_a = 1'b0;
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        z_busy_seen  = 1'b0;
        rst     = 1'b0;
        start_a = 1'b0;
        rand_a  = 1'b0;
        start_z = 1'b0;
        rand_z  = 1'b0;
        #1;
        test_reset();
        test_fixed_delay();
        test_hold_release();
        test_abort();
        test_random();
        test_zero_delay();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
